// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - RV32I decode stage feeding a DEPTH-entry in-order output FIFO
// Optional M-extension decode is enabled by defining MULDIV_EN.
module instr_decode_stage #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic               inValid,
    output logic               inReady,
    input  logic [31:0]        instr,
    input  logic [XLEN-1:0]    pc,
    output logic [4:0]         regNum0,
    output logic [4:0]         regNum1,
    input  logic [XLEN-1:0]    regReadData0,
    input  logic [XLEN-1:0]    regReadData1,
    output logic               outValid,
    input  logic               outReady,
    output logic [ALUOP_W-1:0] aluOp,
    output logic [XLEN-1:0]    aluX,
    output logic [XLEN-1:0]    aluY,
    output logic [XLEN-1:0]    storeData,
    output logic [4:0]         rd,
    output logic               regWriteEnable,
    output logic               memRead,
    output logic               memWrite,
    output logic [2:0]         func3Out,
    output logic               branch,
    output logic               jump,
    output logic [XLEN-1:0]    outPc,
    output logic               illegal
`ifdef MULDIV_EN
    ,
    output logic               mulDiv,
    output logic [2:0]         mulDivOp
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(9);

    typedef struct packed {
        logic [ALUOP_W-1:0] aluOp;
        logic [XLEN-1:0]    aluX;
        logic [XLEN-1:0]    aluY;
        logic [XLEN-1:0]    storeData;
        logic [4:0]         rd;
        logic               regWriteEnable;
        logic               memRead;
        logic               memWrite;
        logic [2:0]         func3;
        logic               branch;
        logic               jump;
        logic [XLEN-1:0]    pc;
        logic               illegal;
`ifdef MULDIV_EN
        logic               mulDiv;
        logic [2:0]         mulDivOp;
`endif
    } bundle_t;

    function automatic logic [ALUOP_W-1:0] baseOp(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    baseOp = alt ? ALU_SUB : ALU_ADD;
            3'd1:    baseOp = ALU_SLL;
            3'd2:    baseOp = ALU_SLT;
            3'd3:    baseOp = ALU_SLTU;
            3'd4:    baseOp = ALU_XOR;
            3'd5:    baseOp = alt ? ALU_SRA : ALU_SRL;
            3'd6:    baseOp = ALU_OR;
            default: baseOp = ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode, func7;
    logic [2:0] func3;
    logic signed [11:0] immI12, immS12;
    logic signed [31:0] immU32;
    logic signed [20:0] immJ21;
    logic [XLEN-1:0] immI, immS, immU, immJ, shamt;

    assign opcode  = instr[6:0];
    assign func3   = instr[14:12];
    assign func7   = instr[31:25];
    assign regNum0 = instr[19:15];
    assign regNum1 = instr[24:20];

    assign immI12 = instr[31:20];
    assign immS12 = {instr[31:25], instr[11:7]};
    assign immU32 = {instr[31:12], 12'b0};
    assign immJ21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign immI   = XLEN'(immI12);
    assign immS   = XLEN'(immS12);
    assign immU   = XLEN'(immU32);
    assign immJ   = XLEN'(immJ21);
    assign shamt  = XLEN'(instr[24:20]);

    bundle_t dec;
    logic    writesRd, badInstr;

    always_comb begin
        dec       = '0;
        dec.pc    = pc;
        dec.rd    = instr[11:7];
        dec.func3 = func3;
        dec.aluOp = ALU_ADD;
        writesRd  = 1'b0;
        badInstr  = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec.aluX = regReadData0;
                dec.aluY = regReadData1;
                writesRd = 1'b1;
                if (func7 == 7'b0000000)
                    dec.aluOp = baseOp(func3, 1'b0);
                else if (func7 == 7'b0100000 && (func3 == 3'd0 || func3 == 3'd5))
                    dec.aluOp = baseOp(func3, 1'b1);
`ifdef MULDIV_EN
                else if (func7 == 7'b0000001) begin
                    dec.mulDiv   = 1'b1;
                    dec.mulDivOp = func3;
                end
`endif
                else
                    badInstr = 1'b1;
            end
            7'b0010011: begin
                dec.aluX  = regReadData0;
                // shifts take the 5-bit shamt; instr[30] only distinguishes srai
                dec.aluY  = (func3 == 3'd1 || func3 == 3'd5) ? shamt : immI;
                dec.aluOp = baseOp(func3, func3 == 3'd5 && instr[30]);
                writesRd  = 1'b1;
            end
            7'b0000011: begin
                dec.aluX    = regReadData0;
                dec.aluY    = immI;
                dec.memRead = 1'b1;
                writesRd    = 1'b1;
            end
            7'b0100011: begin
                dec.aluX      = regReadData0;
                dec.aluY      = immS;
                dec.storeData = regReadData1;
                dec.memWrite  = 1'b1;
            end
            7'b1100011: begin
                dec.aluX   = regReadData0;
                dec.aluY   = regReadData1;
                dec.branch = 1'b1;
                case (func3)
                    3'd0, 3'd1: dec.aluOp = ALU_SUB;
                    3'd4, 3'd5: dec.aluOp = ALU_SLT;
                    3'd6, 3'd7: dec.aluOp = ALU_SLTU;
                    default:    badInstr  = 1'b1;
                endcase
            end
            7'b0110111: begin
                dec.aluY = immU;
                writesRd = 1'b1;
            end
            7'b0010111: begin
                dec.aluX = pc;
                dec.aluY = immU;
                writesRd = 1'b1;
            end
            7'b1101111: begin
                dec.aluX = pc;
                dec.aluY = immJ;
                dec.jump = 1'b1;
                writesRd = 1'b1;
            end
            7'b1100111: begin
                dec.aluX = regReadData0;
                dec.aluY = immI;
                dec.jump = 1'b1;
                writesRd = 1'b1;
            end
            default: badInstr = 1'b1;
        endcase
        dec.illegal        = badInstr;
        dec.regWriteEnable = writesRd && (instr[11:7] != 5'd0) && !badInstr;
        if (badInstr) begin
            dec.memRead  = 1'b0;
            dec.memWrite = 1'b0;
            dec.branch   = 1'b0;
            dec.jump     = 1'b0;
        end
    end

    bundle_t        mem [DEPTH];
    bundle_t        head;
    logic [PW-1:0]  wrPtr, rdPtr;
    logic [CW-1:0]  count;
    logic           push, pop;

    // inReady depends only on registered count and flush, never on outReady
    assign inReady  = (count < CW'(DEPTH)) && !flush;
    assign outValid = (count != '0);
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady && !flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wrPtr] <= dec;
    end

    assign head           = outValid ? mem[rdPtr] : '0;
    assign aluOp          = head.aluOp;
    assign aluX           = head.aluX;
    assign aluY           = head.aluY;
    assign storeData      = head.storeData;
    assign rd             = head.rd;
    assign regWriteEnable = head.regWriteEnable;
    assign memRead        = head.memRead;
    assign memWrite       = head.memWrite;
    assign func3Out       = head.func3;
    assign branch         = head.branch;
    assign jump           = head.jump;
    assign outPc          = head.pc;
    assign illegal        = head.illegal;
`ifdef MULDIV_EN
    assign mulDiv         = head.mulDiv;
    assign mulDivOp       = head.mulDivOp;
`endif

endmodule
